// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the PC redirect controller: FSM encoding, default drain/hold lengths
// and the architectural register width (`size_X_LEN, 32 unless defined by the build).
`ifndef size_X_LEN
`define size_X_LEN 32
`endif

package pc_redirect_ctrl_pkg;

    localparam int XLEN             = `size_X_LEN;
    localparam int DEF_DRAIN_CYCLES = 3;
    localparam int DEF_HOLD_CYCLES  = 2;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_TAKE  = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    // Counter width large enough to hold the larger of the two preload values.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_cnt.sv
// Loadable down-counter; zero pulses on the decrement that brings the count to zero.
`ifndef size_X_LEN
`define size_X_LEN 32
`endif

module pc_redirect_ctrl_cnt
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = dec && (count == W'(1));

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC redirect sequencer: forwards jump/branch/mret from EX and, when PC_REDIRECT_IRQ_EN is
// defined, drains the pipeline and enters interrupts with a precise return address.
`ifndef size_X_LEN
`define size_X_LEN 32
`endif

module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    enable_design_i,
    input  logic [`size_X_LEN-1:0]  initial_pc_i,
    input  logic                    ex_valid_i,
    input  logic [`size_X_LEN-1:0]  ex_pc_i,
    input  logic                    jump_req_i,
    input  logic                    branch_req_i,
    input  logic [`size_X_LEN-1:0]  target_i,
    input  logic                    mret_req_i,
    input  logic                    irq_req_i,
    input  logic                    irq_enable_i,
    output logic                    jump_inst_o,
    output logic                    branch_inst_o,
    output logic [`size_X_LEN-1:0]  target_pc_o,
    output logic                    irq_prep_o,
    output logic                    mret_inst_o,
    output logic                    flush_o,
    output logic                    stall_if_o,
    output logic                    mepc_we_o,
    output logic [`size_X_LEN-1:0]  mepc_wdata_o,
    output logic                    irq_ack_o
);

    state_e state;
    state_e next;

    logic mret_v;
    logic jump_v;
    logic branch_v;
    logic redirect_v;

    // Priority mret > jump > branch, all qualified by a retiring instruction.
    assign mret_v     = ex_valid_i & mret_req_i;
    assign jump_v     = ex_valid_i & jump_req_i & ~mret_req_i;
    assign branch_v   = ex_valid_i & branch_req_i & ~mret_req_i & ~jump_req_i;
    assign redirect_v = mret_v | jump_v | branch_v;

    assign target_pc_o = target_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= ST_BOOT;
        end else if (enable_design_i) begin
            state <= next;
        end
    end

`ifdef PC_REDIRECT_IRQ_EN
    localparam int CNT_W = cnt_width(DRAIN_CYCLES, HOLD_CYCLES);

    logic [`size_X_LEN-1:0] epc_r;
    logic drain_load;
    logic drain_dec;
    logic drain_zero;
    logic hold_load;
    logic hold_dec;
    logic hold_zero;

    pc_redirect_ctrl_cnt #(.W(CNT_W)) u_drain_cnt (
        .clk      (clk_i),
        .rst      (reset_i),
        .load     (drain_load),
        .load_val (CNT_W'(DRAIN_CYCLES)),
        .dec      (drain_dec),
        .zero     (drain_zero)
    );

    pc_redirect_ctrl_cnt #(.W(CNT_W)) u_hold_cnt (
        .clk      (clk_i),
        .rst      (reset_i),
        .load     (hold_load),
        .load_val (CNT_W'(HOLD_CYCLES)),
        .dec      (hold_dec),
        .zero     (hold_zero)
    );

    // Return address follows every retirement, including redirects suppressed during DRAIN.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            epc_r <= initial_pc_i;
        end else if (enable_design_i && ex_valid_i) begin
            epc_r <= (jump_req_i || branch_req_i) ? target_i : ex_pc_i + `size_X_LEN'(4);
        end
    end

    assign stall_if_o   = (state == ST_DRAIN);
    assign mepc_wdata_o = mepc_we_o ? epc_r : '0;
`else
    logic unused_irq_inputs;

    assign unused_irq_inputs = ^{irq_req_i, irq_enable_i, initial_pc_i, ex_pc_i};
    assign stall_if_o        = 1'b0;
    assign mepc_wdata_o      = '0;
`endif

    always_comb begin
        next          = state;
        jump_inst_o   = 1'b0;
        branch_inst_o = 1'b0;
        mret_inst_o   = 1'b0;
        flush_o       = 1'b0;
        irq_prep_o    = 1'b0;
        mepc_we_o     = 1'b0;
        irq_ack_o     = 1'b0;
`ifdef PC_REDIRECT_IRQ_EN
        drain_load    = 1'b0;
        drain_dec     = 1'b0;
        hold_load     = 1'b0;
        hold_dec      = 1'b0;
`endif
        if (enable_design_i) begin
            case (state)
                ST_BOOT: next = ST_RUN;
                ST_RUN: begin
                    jump_inst_o   = jump_v;
                    branch_inst_o = branch_v;
                    mret_inst_o   = mret_v;
                    flush_o       = redirect_v;
`ifdef PC_REDIRECT_IRQ_EN
                    if (!redirect_v && irq_req_i && irq_enable_i) begin
                        next       = ST_DRAIN;
                        drain_load = 1'b1;
                    end
`endif
                end
`ifdef PC_REDIRECT_IRQ_EN
                // Jumps and branches retire silently here; only mret can abort the drain.
                ST_DRAIN: begin
                    mret_inst_o = mret_v;
                    flush_o     = mret_v;
                    if (mret_v) begin
                        next = ST_RUN;
                    end else begin
                        drain_dec = 1'b1;
                        if (drain_zero) begin
                            next = (irq_req_i && irq_enable_i) ? ST_TAKE : ST_RUN;
                        end
                    end
                end
                ST_TAKE: begin
                    irq_prep_o = 1'b1;
                    flush_o    = 1'b1;
                    mepc_we_o  = 1'b1;
                    irq_ack_o  = 1'b1;
                    hold_load  = 1'b1;
                    next       = ST_HOLD;
                end
                ST_HOLD: begin
                    jump_inst_o   = jump_v;
                    branch_inst_o = branch_v;
                    mret_inst_o   = mret_v;
                    flush_o       = redirect_v;
                    hold_dec      = 1'b1;
                    if (hold_zero) begin
                        next = ST_RUN;
                    end
                end
`endif
                default: next = ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: directed scenarios then randomized traffic,
// checked against a cycle-level behavioural model (honours PC_REDIRECT_IRQ_EN).
`ifndef size_X_LEN
`define size_X_LEN 32
`endif

module tb_pc_redirect_ctrl;

    localparam int XW    = `size_X_LEN;
    localparam int DRAIN = 3;
    localparam int HOLD  = 2;
`ifdef PC_REDIRECT_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, enable, ex_valid, jump_req, branch_req, mret_req, irq_req, irq_enable;
    logic [XW-1:0] initial_pc, ex_pc, target;
    logic          jump_inst, branch_inst, irq_prep, mret_inst, flush, stall_if, mepc_we, irq_ack;
    logic [XW-1:0] target_pc, mepc_wdata;

    typedef struct packed {
        logic          j, b, m, prep, flush, stall, we, ack;
        logic [XW-1:0] tpc, wdata;
    } vec_t;

    vec_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Behavioural model state: phase lengths rather than an encoded FSM.
    bit            booted;
    int            drain_left, hold_left;
    bit            in_take;
    logic [XW-1:0] epc;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.DRAIN_CYCLES(DRAIN), .HOLD_CYCLES(HOLD)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .enable_design_i (enable),
        .initial_pc_i    (initial_pc),
        .ex_valid_i      (ex_valid),
        .ex_pc_i         (ex_pc),
        .jump_req_i      (jump_req),
        .branch_req_i    (branch_req),
        .target_i        (target),
        .mret_req_i      (mret_req),
        .irq_req_i       (irq_req),
        .irq_enable_i    (irq_enable),
        .jump_inst_o     (jump_inst),
        .branch_inst_o   (branch_inst),
        .target_pc_o     (target_pc),
        .irq_prep_o      (irq_prep),
        .mret_inst_o     (mret_inst),
        .flush_o         (flush),
        .stall_if_o      (stall_if),
        .mepc_we_o       (mepc_we),
        .mepc_wdata_o    (mepc_wdata),
        .irq_ack_o       (irq_ack)
    );

    task automatic step(input bit rst, input bit en, input bit vld, input logic [XW-1:0] pc,
                        input bit j, input bit b, input bit m, input logic [XW-1:0] tgt,
                        input bit irq, input bit ie, input bit chk);
        vec_t e;
        bit   mv, jv, bv, fwd, take;
        @(negedge clk);
        reset = rst; enable = en; ex_valid = vld; ex_pc = pc;
        jump_req = j; branch_req = b; mret_req = m; target = tgt;
        irq_req = irq; irq_enable = ie;
        mv   = vld & m;
        jv   = vld & j & ~m;
        bv   = vld & b & ~m & ~j;
        fwd  = en && booted && drain_left == 0 && !in_take;
        take = en && in_take;
        e.j     = fwd & jv;
        e.b     = fwd & bv;
        e.m     = en && booted && !in_take && mv;
        e.prep  = take;
        e.ack   = take;
        e.we    = take;
        e.flush = e.j | e.b | e.m | take;
        e.stall = (drain_left != 0);
        e.wdata = take ? epc : '0;
        e.tpc   = tgt;
        if (chk) q.push_back(e);
        if (rst) begin
            booted = 0; drain_left = 0; hold_left = 0; in_take = 0; epc = initial_pc;
        end else if (en) begin
            if (vld) epc = (j || b) ? tgt : pc + XW'(4);
            if (!booted) begin
                booted = 1;
            end else if (in_take) begin
                in_take = 0; hold_left = HOLD;
            end else if (drain_left > 0) begin
                if (mv) drain_left = 0;
                else if (drain_left == 1) begin
                    drain_left = 0;
                    in_take = irq && ie;
                end else drain_left--;
            end else if (hold_left > 0) begin
                hold_left--;
            end else if (IRQ_EN && irq && ie && !(mv || jv || bv)) begin
                drain_left = DRAIN;
            end
        end
    endtask

    task automatic idle(input bit irq, input bit ie);
        step(0, 1, 0, '0, 0, 0, 0, '0, irq, ie, 1);
    endtask

    task automatic retire(input logic [XW-1:0] pc, input bit j, input bit b, input bit m,
                          input logic [XW-1:0] tgt, input bit irq, input bit ie);
        step(0, 1, 1, pc, j, b, m, tgt, irq, ie, 1);
    endtask

    task automatic cmp(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                cmp("jump_inst",   XW'(jump_inst),   XW'(e.j));
                cmp("branch_inst", XW'(branch_inst), XW'(e.b));
                cmp("mret_inst",   XW'(mret_inst),   XW'(e.m));
                cmp("irq_prep",    XW'(irq_prep),    XW'(e.prep));
                cmp("flush",       XW'(flush),       XW'(e.flush));
                cmp("stall_if",    XW'(stall_if),    XW'(e.stall));
                cmp("mepc_we",     XW'(mepc_we),     XW'(e.we));
                cmp("irq_ack",     XW'(irq_ack),     XW'(e.ack));
                cmp("target_pc",   target_pc,        e.tpc);
                cmp("mepc_wdata",  mepc_wdata,       e.wdata);
            end
        end
    end

    initial begin
        bit            irq_l, ie_l;
        logic [XW-1:0] pc, tgt;
        reset = 1; enable = 0; ex_valid = 0; jump_req = 0; branch_req = 0; mret_req = 0;
        irq_req = 0; irq_enable = 0; ex_pc = '0; target = '0; initial_pc = XW'('h1000);
        step(1, 0, 0, '0, 0, 0, 0, '0, 0, 0, 0);
        step(1, 0, 0, '0, 0, 0, 0, '0, 0, 0, 1);
        step(0, 0, 0, '0, 0, 0, 0, '0, 0, 0, 1);
        idle(0, 0);
        // Jump forwarding in RUN.
        retire(XW'('h10), 1, 0, 0, XW'('h100), 0, 0);
        // Interrupt entry with retirements during the drain.
        idle(1, 1);
        retire(XW'('h20), 0, 0, 0, '0, 1, 1);
        retire(XW'('h24), 0, 0, 0, '0, 1, 1);
        retire(XW'('h28), 0, 0, 0, '0, 1, 1);
        idle(0, 1); idle(0, 1); idle(0, 1); idle(0, 1);
        // Branch retiring during the drain becomes the return address.
        idle(1, 1);
        retire(XW'('h40), 0, 1, 0, XW'('h80), 1, 1);
        idle(1, 1); idle(1, 1);
        idle(0, 1); idle(0, 1); idle(0, 1); idle(0, 1);
        // mret aborts the drain; the level irq re-enters, then drops before expiry.
        idle(1, 1);
        retire(XW'('h50), 0, 0, 1, XW'('h200), 1, 1);
        idle(1, 1); idle(1, 1);
        idle(0, 1); idle(0, 1); idle(0, 1); idle(0, 1);
        // Masked interrupt: no stall, jumps still forwarded.
        idle(1, 0);
        retire(XW'('h60), 1, 0, 0, XW'('h300), 1, 0);
        idle(1, 0);
        // Reset in the second drain cycle.
        idle(1, 1); idle(1, 1);
        step(1, 1, 0, '0, 0, 0, 0, '0, 1, 1, 1);
        step(0, 1, 0, '0, 0, 0, 0, '0, 0, 0, 1);
        idle(0, 0);
        // Enable low mid-drain freezes everything; wrapped return address.
        retire(XW'('hFFFF_FFFC), 0, 0, 0, '0, 1, 1);
        idle(1, 1);
        step(0, 0, 0, '0, 0, 0, 0, '0, 1, 1, 1);
        step(0, 0, 0, '0, 0, 0, 0, '0, 1, 1, 1);
        idle(1, 1); idle(1, 1); idle(1, 1);
        idle(0, 1); idle(0, 1); idle(0, 1);
        irq_l = 0; ie_l = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 4) irq_l = ~irq_l;
            if ($urandom_range(99) < 2) ie_l = ~ie_l;
            pc  = ($urandom_range(9) == 0) ? XW'('hFFFF_FFFC) : (XW'($urandom) & ~XW'(3));
            tgt = XW'($urandom) & ~XW'(3);
            step($urandom_range(199) == 0, $urandom_range(9) != 0, $urandom_range(9) < 6, pc,
                 $urandom_range(99) < 12, $urandom_range(99) < 12, $urandom_range(99) < 6, tgt,
                 irq_l, ie_l, 1);
        end
        repeat (3) @(negedge clk);
        #5;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_queue: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
